// File: rtl/rnd_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rnd_share_arbiter                                            |
// | Description : Round-robin sharing of one random_generator among NUM_REQ    |
// |               requesters. Steps the generator once per delivered word and  |
// |               routes each fresh word to a single granted requester, with   |
// |               bursts bounded by MAX_BURST.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rnd_share_arbiter #(
    parameter int DATA_WDTH = 32,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [DATA_WDTH-1:0] gen_rnd,
    output logic                 gen_enable,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 rnd_valid,
    output logic [DATA_WDTH-1:0] rnd_out,
    output logic [15:0]          words_served
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BCNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    localparam logic [IDX_W-1:0]  LAST_RST   = IDX_W'(NUM_REQ - 1);
    localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STEP    = 2'd1,
        S_DELIVER = 2'd2
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    winner;
    logic [IDX_W-1:0]    last;
    logic [BCNT_W-1:0]   burst_cnt;
    logic [15:0]         served_cnt;

    logic [IDX_W-1:0]    arb_ptr;
    logic                arb_found;
    logic [IDX_W-1:0]    arb_idx;
    logic                burst_more;

    // In DELIVER a finishing burst re-arbitrates from the current winner, which
    // is the value 'last' takes at the end of this cycle; in IDLE 'last' is current.
    assign arb_ptr = (state == S_DELIVER) ? winner : last;

    // Burst continues only while the winner still requests and the bound is not hit.
    assign burst_more = req[winner] && (burst_cnt < BURST_LAST);

    // Rotating-priority search starting just above the pointer, wrapping around;
    // the pointer itself is checked last so it only wins when nobody else asks.
    always_comb begin
        int cand;
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = int'(arb_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (req[cand[IDX_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Controller: IDLE -> STEP (pulse generator enable) -> DELIVER (present word).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            gen_enable <= 1'b0;
            gnt        <= '0;
            rnd_valid  <= 1'b0;
            served_cnt <= '0;
            burst_cnt  <= '0;
            last       <= LAST_RST;
            winner     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    gen_enable <= 1'b0;
                    gnt        <= '0;
                    rnd_valid  <= 1'b0;
                    if (arb_found) begin
                        winner     <= arb_idx;
                        burst_cnt  <= '0;
                        gen_enable <= 1'b1;
                        state      <= S_STEP;
                    end
                end
                S_STEP: begin
                    // Word is committed regardless of what req does now.
                    gen_enable <= 1'b0;
                    rnd_valid  <= 1'b1;
                    gnt        <= NUM_REQ'(1) << winner;
                    state      <= S_DELIVER;
                end
                S_DELIVER: begin
                    rnd_valid  <= 1'b0;
                    gnt        <= '0;
                    served_cnt <= served_cnt + 16'd1;
                    if (burst_more) begin
                        burst_cnt  <= burst_cnt + BCNT_W'(1);
                        gen_enable <= 1'b1;
                        state      <= S_STEP;
                    end else begin
                        last      <= winner;
                        burst_cnt <= '0;
                        if (arb_found) begin
                            winner     <= arb_idx;
                            gen_enable <= 1'b1;
                            state      <= S_STEP;
                        end else begin
                            gen_enable <= 1'b0;
                            state      <= S_IDLE;
                        end
                    end
                end
                default: begin
                    gen_enable <= 1'b0;
                    gnt        <= '0;
                    rnd_valid  <= 1'b0;
                    burst_cnt  <= '0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

    assign rnd_out      = rnd_valid ? gen_rnd : '0;
    assign words_served = served_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rnd_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rnd_share_arbiter                                         |
// | Description : Scoreboard bench for rnd_share_arbiter with LCG generator    |
// |               models; main instance MAX_BURST=2, second MAX_BURST=1.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_rnd_share_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    // main instance (MAX_BURST=2)
    logic [NR-1:0] req = '0;
    logic [DW-1:0] gen_rnd;
    logic          gen_enable;
    logic [NR-1:0] gnt;
    logic          rnd_valid;
    logic [DW-1:0] rnd_out;
    logic [15:0]   words_served;
    logic [31:0]   gen_state = 32'd123456;

    // second instance (MAX_BURST=1)
    logic [NR-1:0] req1 = '0;
    logic [DW-1:0] gen_rnd1;
    logic          gen_enable1;
    logic [NR-1:0] gnt1;
    logic          rnd_valid1;
    logic [DW-1:0] rnd_out1;
    logic [15:0]   words_served1;
    logic [31:0]   gen_state1 = 32'd123456;

    typedef struct {
        logic [NR-1:0] g;
        logic [15:0]   ws;
    } exp_t;

    exp_t q[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] lcg(input logic [31:0] s);
        return s * 32'd1664525 + 32'd1013904223;
    endfunction

    // generator models: new value visible the cycle after enable is sampled
    always @(posedge clk) if (gen_enable)  gen_state  <= lcg(gen_state);
    always @(posedge clk) if (gen_enable1) gen_state1 <= lcg(gen_state1);
    assign gen_rnd  = gen_state;
    assign gen_rnd1 = gen_state1;

    rnd_share_arbiter #(.DATA_WDTH(DW), .NUM_REQ(NR), .MAX_BURST(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gen_rnd(gen_rnd),
        .gen_enable(gen_enable), .gnt(gnt), .rnd_valid(rnd_valid),
        .rnd_out(rnd_out), .words_served(words_served)
    );

    rnd_share_arbiter #(.DATA_WDTH(DW), .NUM_REQ(NR), .MAX_BURST(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .gen_rnd(gen_rnd1),
        .gen_enable(gen_enable1), .gnt(gnt1), .rnd_valid(rnd_valid1),
        .rnd_out(rnd_out1), .words_served(words_served1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents a word
    initial begin
        exp_t e;
        logic [31:0] es, es1;
        int pulses, pulses1;
        bit  ws_pend, pv, pv1;
        logic [15:0] ws_exp;
        es = 32'd123456; es1 = 32'd123456;
        pulses = 0; pulses1 = 0; ws_pend = 0; pv = 0; pv1 = 0; ws_exp = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pulses = 0; pulses1 = 0; ws_pend = 0; pv = 0; pv1 = 0;
            end else begin
                if (ws_pend) begin
                    chk("words_served_after", {48'd0, words_served}, {48'd0, ws_exp});
                    ws_pend = 0;
                end
                if (!rnd_valid && rnd_out != '0) chk("rnd_out_quiet", {32'd0, rnd_out}, 64'd0);
                if (gen_enable) pulses++;
                if (gen_enable1) pulses1++;
                if (rnd_valid) begin
                    chk("valid_back_to_back", {63'd0, pv}, 64'd0);
                    chk("gen_pulses", pulses, 1);
                    pulses = 0;
                    es = lcg(es);
                    chk("rnd_out", {32'd0, rnd_out}, {32'd0, es});
                    if (q.size() == 0) begin
                        chk("unexpected_word_gnt", {60'd0, gnt}, 64'd0);
                    end else begin
                        e = q.pop_front();
                        chk("gnt", {60'd0, gnt}, {60'd0, e.g});
                        ws_pend = 1;
                        ws_exp  = e.ws;
                    end
                end
                if (rnd_valid1) begin
                    chk("b1_valid_back_to_back", {63'd0, pv1}, 64'd0);
                    chk("b1_gen_pulses", pulses1, 1);
                    pulses1 = 0;
                    es1 = lcg(es1);
                    chk("b1_rnd_out", {32'd0, rnd_out1}, {32'd0, es1});
                    if (q1.size() == 0) begin
                        chk("b1_unexpected_word_gnt", {60'd0, gnt1}, 64'd0);
                    end else begin
                        e = q1.pop_front();
                        chk("b1_gnt", {60'd0, gnt1}, {60'd0, e.g});
                    end
                end
                pv  = rnd_valid;
                pv1 = rnd_valid1;
            end
        end
    end

    task automatic push(input logic [NR-1:0] g, input logic [15:0] ws);
        exp_t e;
        e.g = g; e.ws = ws;
        q.push_back(e);
    endtask

    task automatic push1(input logic [NR-1:0] g);
        exp_t e;
        e.g = g; e.ws = '0;
        q1.push_back(e);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // waits for a delivery whose pre-increment count equals target; returns cycles waited
    task automatic wait_word(input bit inst, input logic [15:0] target, output int cyc);
        cyc = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (!inst && rnd_valid && words_served == target) begin cyc = i; break; end
            if (inst && rnd_valid1 && words_served1 == target) begin cyc = i; break; end
        end
        if (cyc < 0) begin
            errors++;
            $display("FAIL wait_word timeout: got none expected count %0h", target);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (q.size() == 0 && q1.size() == 0) break;
        end
        repeat (4) @(negedge clk);
        chk("scoreboard_drained", q.size() + q1.size(), 0);
    endtask

    initial begin
        int cyc;
        // reset state
        #2;
        chk("rst_gen_enable", {63'd0, gen_enable}, 64'd0);
        chk("rst_gnt", {60'd0, gnt}, 64'd0);
        chk("rst_rnd_valid", {63'd0, rnd_valid}, 64'd0);
        chk("rst_rnd_out", {32'd0, rnd_out}, 64'd0);
        chk("rst_words_served", {48'd0, words_served}, 64'd0);
        reset_dut();

        // MAX_BURST=1, all requesting: strict per-word rotation
        push1(4'b0001); push1(4'b0010); push1(4'b0100); push1(4'b1000);
        push1(4'b0001); push1(4'b0010);
        @(negedge clk);
        req1 = 4'b1111;
        wait_word(1'b1, 16'd5, cyc);
        req1 = '0;
        drain();

        // single requester: word every 2 cycles starting at cycle 2
        reset_dut();
        push(4'b0001, 16'd1); push(4'b0001, 16'd2);
        push(4'b0001, 16'd3); push(4'b0001, 16'd4);
        @(negedge clk);
        req = 4'b0001;
        wait_word(1'b0, 16'd3, cyc);
        req = '0;
        chk("single_4th_word_cycle", cyc, 8);
        drain();

        // contention 0101, burst of 2: 0,0,2,2,0,0,2,2
        reset_dut();
        push(4'b0001, 16'd1); push(4'b0001, 16'd2);
        push(4'b0100, 16'd3); push(4'b0100, 16'd4);
        push(4'b0001, 16'd5); push(4'b0001, 16'd6);
        push(4'b0100, 16'd7); push(4'b0100, 16'd8);
        @(negedge clk);
        req = 4'b0101;
        wait_word(1'b0, 16'd7, cyc);
        req = '0;
        chk("contention_8th_word_cycle", cyc, 16);
        drain();
        chk("contention_words_served", {48'd0, words_served}, 64'd8);

        // requester 0 drops during its first STEP: word still goes to 0, then 1
        reset_dut();
        push(4'b0001, 16'd1); push(4'b0010, 16'd2); push(4'b0010, 16'd3);
        @(negedge clk);
        req = 4'b0011;
        @(negedge clk);
        chk("drop_step_gen_enable", {63'd0, gen_enable}, 64'd1);
        chk("drop_step_rnd_valid", {63'd0, rnd_valid}, 64'd0);
        req = 4'b0010;
        wait_word(1'b0, 16'd2, cyc);
        req = '0;
        drain();

        // reset asserted during STEP, then restart with requester 2
        reset_dut();
        push(4'b1000, 16'd1); push(4'b1000, 16'd2);
        @(negedge clk);
        req = 4'b1000;
        wait_word(1'b0, 16'd1, cyc);
        @(negedge clk);
        chk("pre_reset_in_step", {63'd0, gen_enable}, 64'd1);
        #2;
        rst_n = 1'b0;
        req = 4'b0100;
        #1;
        chk("rst_step_gen_enable", {63'd0, gen_enable}, 64'd0);
        chk("rst_step_gnt", {60'd0, gnt}, 64'd0);
        chk("rst_step_rnd_valid", {63'd0, rnd_valid}, 64'd0);
        chk("rst_step_rnd_out", {32'd0, rnd_out}, 64'd0);
        chk("rst_step_words_served", {48'd0, words_served}, 64'd0);
        push(4'b0100, 16'd1); push(4'b0100, 16'd2);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_step", {63'd0, gen_enable}, 64'd1);
        @(negedge clk);
        chk("post_reset_first_valid", {63'd0, rnd_valid}, 64'd1);
        chk("post_reset_count_restart", {48'd0, words_served}, 64'd0);
        wait_word(1'b0, 16'd1, cyc);
        req = '0;
        drain();

        // counter wrap from a forced 0xFFFE
        @(negedge clk);
        force u_dut.served_cnt = 16'hFFFE;
        @(negedge clk);
        release u_dut.served_cnt;
        @(negedge clk);
        chk("wrap_preload", {48'd0, words_served}, 64'hFFFE);
        push(4'b0001, 16'hFFFF); push(4'b0001, 16'h0000); push(4'b0001, 16'h0001);
        req = 4'b0001;
        wait_word(1'b0, 16'h0000, cyc);
        req = '0;
        drain();
        chk("wrap_final", {48'd0, words_served}, 64'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
